burst_symbol_source: RTL and testbench

Upstream feeder for the GMSK transmit path. Buffers one normal-burst payload of 116 bits (114 data + 2 stealing flags), inserts tail bits and the training sequence, differentially encodes the result, and presents one symbol per modulator symbol interval on `symbol`. It then holds the line idle for a guard period. It drives the symbol input of the burst timing/modulator stage and advances on that stage's `next_symbol_strobe`.

---
 rtl/burst_symbol_source.sv | 135 +++++++++++++
 tb/tb_burst_symbol_source.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/burst_symbol_source.sv
// Normal-burst symbol source: buffers 116 payload bits, frames them with tail bits
// and the training sequence, differentially encodes, and paces output on the modulator strobe.
module burst_symbol_source #(
  parameter int GUARD_SYMBOLS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_bit,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [25:0] training_sequence,
  input  logic        fire,
  output logic        armed,
  input  logic        next_symbol_strobe,
  output logic        symbol,
  output logic        symbol_valid,
  output logic        busy,
  output logic        burst_done
);

  localparam int GW = $clog2(GUARD_SYMBOLS + 1);

  typedef enum logic [1:0] {LOAD, ARMED, SEND, GUARD} state_t;

  state_t          state, state_next;
  logic [115:0]    payload;
  logic [25:0]     tsc;
  logic [6:0]      wr_count;
  logic [7:0]      idx;
  logic [GW-1:0]   guard_cnt;
  logic            cur_raw;
  logic            strobe_d;

  logic            advance, take, start, send_last, guard_last;
  logic [7:0]      nidx;
  logic [6:0]      bsel;
  logic [4:0]      tsel;
  logic            raw_next;

  assign advance    = next_symbol_strobe & ~strobe_d;
  assign load_ready = (state == LOAD) & ~reset;
  assign armed      = (state == ARMED);

  always_comb begin
    state_next = state;
    take       = 1'b0;
    start      = 1'b0;
    send_last  = 1'b0;
    guard_last = 1'b0;
    case (state)
      LOAD:  if (load_valid) begin
               take = 1'b1;
               if (wr_count == 7'd115) state_next = ARMED;
             end
      ARMED: if (fire) begin
               start      = 1'b1;
               state_next = SEND;
             end
      SEND:  if (advance && idx == 8'd147) begin
               send_last  = 1'b1;
               state_next = GUARD;
             end
      GUARD: if (advance && guard_cnt == GW'(GUARD_SYMBOLS - 1)) begin
               guard_last = 1'b1;
               state_next = LOAD;
             end
      default: state_next = LOAD;
    endcase
  end

  // Raw bit of the symbol about to be presented (idx+1). Payload sits at idx-3 up to the
  // second stealing flag and at idx-29 after the training sequence.
  always_comb begin
    nidx     = idx + 8'd1;
    bsel     = (nidx < 8'd87) ? 7'(nidx - 8'd3) : 7'(nidx - 8'd29);
    tsel     = 5'(8'd86 - nidx);
    raw_next = 1'b0;
    if (nidx >= 8'd3 && nidx <= 8'd60)        raw_next = payload[bsel];
    else if (nidx >= 8'd61 && nidx <= 8'd86)  raw_next = tsc[tsel];
    else if (nidx >= 8'd87 && nidx <= 8'd144) raw_next = payload[bsel];
  end

  // Payload and TSC storage are never cleared, only overwritten.
  always_ff @(posedge clock) begin
    if (!reset && take)  payload[wr_count] <= load_bit;
    if (!reset && start) tsc <= training_sequence;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= LOAD;
      wr_count     <= '0;
      strobe_d     <= 1'b0;
      idx          <= '0;
      guard_cnt    <= '0;
      cur_raw      <= 1'b0;
      symbol       <= 1'b1;
      symbol_valid <= 1'b0;
      busy         <= 1'b0;
      burst_done   <= 1'b0;
    end else begin
      state      <= state_next;
      strobe_d   <= next_symbol_strobe;
      burst_done <= guard_last;
      if (take) wr_count <= wr_count + 7'd1;
      // Index 0 is always a tail zero encoded against an initial reference of 1.
      if (start) begin
        idx          <= '0;
        cur_raw      <= 1'b0;
        symbol       <= 1'b1;
        symbol_valid <= 1'b1;
        busy         <= 1'b1;
      end
      if (state == SEND && advance) begin
        if (send_last) begin
          guard_cnt    <= '0;
          symbol       <= 1'b1;
          symbol_valid <= 1'b0;
        end else begin
          idx     <= nidx;
          cur_raw <= raw_next;
          symbol  <= raw_next ^ cur_raw;
        end
      end
      if (state == GUARD && advance) begin
        guard_cnt <= guard_cnt + GW'(1);
        if (guard_last) begin
          busy     <= 1'b0;
          wr_count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_symbol_source.sv
// Bench for burst_symbol_source: table of burst scenarios, each checked symbol-by-symbol
// against a segment-concatenation model of the burst layout plus differential encoding.
module tb_burst_symbol_source;
  localparam int GUARD = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_bit = 1'b0, load_valid = 1'b0, fire = 1'b0, next_symbol_strobe = 1'b0;
  logic [25:0] training_sequence = '0;
  logic        load_ready, armed, symbol, symbol_valid, busy, burst_done;

  int vectors = 0, miscompares = 0;
  int done_seen;
  logic first_done, first_busy, first_lr;

  always #5 clock = ~clock;

  burst_symbol_source #(.GUARD_SYMBOLS(GUARD)) dut (
    .clock(clock), .reset(reset),
    .load_bit(load_bit), .load_valid(load_valid), .load_ready(load_ready),
    .training_sequence(training_sequence), .fire(fire), .armed(armed),
    .next_symbol_strobe(next_symbol_strobe),
    .symbol(symbol), .symbol_valid(symbol_valid), .busy(busy), .burst_done(burst_done)
  );

  typedef struct {
    int          pat;       // 0 zeros, 1 ones, 2 alternating 1,0,.., 3 random
    logic [25:0] tsc;
    int          period;
    int          hold;
    int          reset_at;  // -1: no reset
    int          exp_ones;  // -1: model only
    int          exp_s0;
    int          exp_s3;
    int          exp_s145;
  } scen_t;

  scen_t tbl[7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [147:0] ref_symbols(input logic [115:0] p, input logic [25:0] t);
    bit raw[$];
    logic [147:0] s;
    bit prev;
    for (int k = 0; k < 3; k++) raw.push_back(1'b0);
    for (int k = 0; k <= 56; k++) raw.push_back(p[k]);
    raw.push_back(p[57]);
    for (int b = 25; b >= 0; b--) raw.push_back(t[b]);
    raw.push_back(p[58]);
    for (int k = 59; k <= 115; k++) raw.push_back(p[k]);
    for (int k = 0; k < 3; k++) raw.push_back(1'b0);
    prev = 1'b1;
    for (int i = 0; i < 148; i++) begin
      s[i] = raw[i] ^ prev;
      prev = raw[i];
    end
    return s;
  endfunction

  task automatic interval(input int period, input int hold);
    for (int c = 0; c < period; c++) begin
      next_symbol_strobe = (c < hold);
      @(negedge clock);
      if (c == 0) begin
        first_done = burst_done;
        first_busy = busy;
        first_lr   = load_ready;
      end
      if (burst_done) done_seen++;
    end
  endtask

  task automatic load_payload(input logic [115:0] p);
    for (int k = 0; k < 116; k++) begin
      load_valid = 1'b1;
      load_bit   = p[k];
      fire       = (k == 50 || k == 115);
      training_sequence = 26'($urandom);
      @(negedge clock);
      if (k == 0)  chk("load_ready_in_load", load_ready, 1'b1);
      if (k == 50) chk("early_fire_ignored", {busy, armed, symbol_valid}, 3'b000);
    end
    fire = 1'b0;
    chk("armed_after_116", {armed, load_ready, busy}, 3'b100);
    // load_valid held in ARMED must not disturb the buffer
    for (int k = 0; k < 3; k++) begin
      load_bit = ~p[k];
      @(negedge clock);
    end
    load_valid = 1'b0;
    chk("armed_holds", armed, 1'b1);
  endtask

  task automatic run(input scen_t s);
    logic [115:0] p;
    logic [147:0] exp;
    int ones, s0, s3, s145;
    bit aborted;
    for (int k = 0; k < 116; k++)
      case (s.pat)
        0:       p[k] = 1'b0;
        1:       p[k] = 1'b1;
        2:       p[k] = ~k[0];
        default: p[k] = 1'($urandom_range(0, 1));
      endcase
    exp = ref_symbols(p, s.tsc);
    load_payload(p);
    training_sequence = s.tsc;
    fire = 1'b1;
    @(negedge clock);
    fire = 1'b0;
    training_sequence = 26'($urandom);
    ones = 0; s0 = 0; s3 = 0; s145 = 0; done_seen = 0; aborted = 1'b0;
    for (int i = 0; i < 148 && !aborted; i++) begin
      chk($sformatf("sym_idx%0d", i), {symbol_valid, busy, symbol}, {2'b11, exp[i]});
      if (symbol) ones++;
      if (i == 0)   s0   = int'(symbol);
      if (i == 3)   s3   = int'(symbol);
      if (i == 145) s145 = int'(symbol);
      if (i == s.reset_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_mid_burst", {symbol, symbol_valid, busy, load_ready, burst_done}, 5'b10010);
        for (int c = 0; c < 4; c++) begin
          @(negedge clock);
          if (burst_done) done_seen++;
        end
        chk("no_done_after_reset", done_seen, 0);
        aborted = 1'b1;
      end else begin
        interval(s.period, s.hold);
      end
    end
    if (!aborted) begin
      for (int g = 0; g < GUARD; g++) begin
        chk($sformatf("guard%0d", g), {symbol, symbol_valid, busy, burst_done}, 4'b1010);
        interval(s.period, s.hold);
        if (g == GUARD - 1)
          chk("burst_end", {first_done, first_busy, first_lr, symbol_valid}, 4'b1010);
      end
      chk("done_pulses", done_seen, 1);
      if (s.exp_ones >= 0) begin
        chk("ones_count", ones, s.exp_ones);
        chk("s0_s3_s145", {s0[0], s3[0], s145[0]},
            {s.exp_s0[0], s.exp_s3[0], s.exp_s145[0]});
      end
    end
  endtask

  initial begin
    tbl[0] = '{0, 26'h0000000, 4, 1, -1,   1, 1, 0, 0};
    tbl[1] = '{1, 26'h3FFFFFF, 4, 1, -1,   3, 1, 1, 1};
    tbl[2] = '{2, 26'h0970897, 6, 3, -1, 129, 1, 1, 0};
    tbl[3] = '{3, 26'($urandom), 3, 2, 70,  -1, 0, 0, 0};
    tbl[4] = '{2, 26'($urandom), 5, 1, -1,  -1, 0, 0, 0};
    tbl[5] = '{3, 26'($urandom), 4, 3, -1,  -1, 0, 0, 0};
    tbl[6] = '{3, 26'($urandom), 2, 1, -1,  -1, 0, 0, 0};

    @(negedge clock);
    @(negedge clock);
    chk("reset_state", {symbol, symbol_valid, busy, armed, burst_done, load_ready}, 6'b100000);
    reset = 1'b0;
    #1;
    chk("load_ready_after_reset", load_ready, 1'b1);
    @(negedge clock);

    for (int n = 0; n < 7; n++) run(tbl[n]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
